// File: rtl/rx_frame_parser.sv
// Sync-hunting byte-stream frame parser with a first-word-fall-through payload FIFO and per-frame terminator status.
// Optional feature macro: FRAME_STATS_EN adds saturating good/bad frame counters (good_cnt, bad_cnt).
module rx_frame_parser #(
    parameter logic [7:0]  SYNC0   = 8'hAA,
    parameter logic [7:0]  SYNC1   = 8'h55,
    parameter int unsigned MAX_LEN = 64,
    parameter int unsigned FIFO_AW = 5
) (
    input  logic        CLK_100_RX,
    input  logic        RESET,
    input  logic [7:0]  rx_byte,
    input  logic        rx_aligned,
    output logic [7:0]  out_data,
    output logic        out_last,
    output logic        out_err,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        overflow,
    output logic        len_err
`ifdef FRAME_STATS_EN
    ,
    output logic [15:0] good_cnt,
    output logic [15:0] bad_cnt
`endif
);
    typedef enum logic [2:0] {
        HUNT = 3'd0,
        S1   = 3'd1,
        LEN  = 3'd2,
        PAY  = 3'd3,
        CSUM = 3'd4
    } state_t;

    localparam int unsigned        DEPTH     = 1 << FIFO_AW;
    localparam logic [7:0]         MAX_LEN_B = MAX_LEN[7:0];
    localparam logic [FIFO_AW:0]   FULL_CNT  = {1'b1, {FIFO_AW{1'b0}}};

    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] data);
        return acc + data;
    endfunction

    state_t           state_r, state_s;
    logic [7:0]       cnt_r, cnt_s;
    logic [7:0]       sum_r, sum_s;
    logic             drop_r, drop_s;
    logic             push_s;
    logic [9:0]       push_entry_s;
    logic             len_err_s;
    logic             len_err_r;
    logic             overflow_r;

    logic [9:0]       mem_r [0:DEPTH-1];
    logic [FIFO_AW:0] wr_ptr_r, rd_ptr_r, rd_ptr_nxt_s;
    logic             full_s, pop_s, wr_en_s, head_avail_s;
    logic [9:0]       out_entry_r;
    logic             out_valid_r;

    assign full_s       = ((wr_ptr_r - rd_ptr_r) == FULL_CNT);
    assign pop_s        = out_valid_r & out_ready;
    assign wr_en_s      = push_s & ~full_s;
    assign rd_ptr_nxt_s = rd_ptr_r + {{FIFO_AW{1'b0}}, pop_s};
    // Uses the pre-edge write pointer so a freshly written entry shows one cycle later.
    assign head_avail_s = (wr_ptr_r != rd_ptr_nxt_s);

    // Parser next-state, push request and length-error decode.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        sum_s        = sum_r;
        drop_s       = drop_r;
        push_s       = 1'b0;
        push_entry_s = 10'h000;
        len_err_s    = 1'b0;
        if (!rx_aligned) begin
            if ((state_r == PAY) || (state_r == CSUM)) begin
                push_s       = 1'b1;
                push_entry_s = {1'b1, 1'b1, 8'h00};
            end else begin
                push_s       = 1'b0;
            end
            state_s = HUNT;
        end else begin
            case (state_r)
                HUNT: begin
                    if (rx_byte == SYNC0) state_s = S1;
                    else                  state_s = HUNT;
                end
                S1: begin
                    if (rx_byte == SYNC1)      state_s = LEN;
                    else if (rx_byte == SYNC0) state_s = S1;
                    else                       state_s = HUNT;
                end
                LEN: begin
                    if ((rx_byte == 8'h00) || (rx_byte > MAX_LEN_B)) begin
                        len_err_s = 1'b1;
                        state_s   = HUNT;
                    end else begin
                        cnt_s   = rx_byte;
                        sum_s   = rx_byte;
                        drop_s  = 1'b0;
                        state_s = PAY;
                    end
                end
                PAY: begin
                    push_s       = 1'b1;
                    push_entry_s = {1'b0, 1'b0, rx_byte};
                    sum_s        = csum_add(sum_r, rx_byte);
                    cnt_s        = cnt_r - 8'd1;
                    drop_s       = drop_r | full_s;
                    if (cnt_r == 8'd1) state_s = CSUM;
                    else               state_s = PAY;
                end
                CSUM: begin
                    push_s       = 1'b1;
                    push_entry_s = {1'b1, (sum_r != rx_byte) | drop_r, rx_byte};
                    state_s      = HUNT;
                end
                default: begin
                    state_s = HUNT;
                end
            endcase
        end
    end

    // Parser state, frame counters and sticky status flags.
    always_ff @(posedge CLK_100_RX or posedge RESET) begin
        if (RESET) begin
            state_r    <= HUNT;
            cnt_r      <= 8'h00;
            sum_r      <= 8'h00;
            drop_r     <= 1'b0;
            len_err_r  <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            sum_r      <= sum_s;
            drop_r     <= drop_s;
            len_err_r  <= len_err_s;
            overflow_r <= overflow_r | (push_s & full_s);
        end
    end

    // FIFO storage write port.
    always_ff @(posedge CLK_100_RX) begin
        if (wr_en_s) mem_r[wr_ptr_r[FIFO_AW-1:0]] <= push_entry_s;
    end

    // FIFO pointers and registered head-of-queue.
    always_ff @(posedge CLK_100_RX or posedge RESET) begin
        if (RESET) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            out_valid_r <= 1'b0;
            out_entry_r <= 10'h000;
        end else begin
            wr_ptr_r    <= wr_ptr_r + {{FIFO_AW{1'b0}}, wr_en_s};
            rd_ptr_r    <= rd_ptr_nxt_s;
            out_valid_r <= head_avail_s;
            if (head_avail_s) out_entry_r <= mem_r[rd_ptr_nxt_s[FIFO_AW-1:0]];
        end
    end

    assign out_data  = out_entry_r[7:0];
    assign out_err   = out_entry_r[8];
    assign out_last  = out_entry_r[9];
    assign out_valid = out_valid_r;
    assign overflow  = overflow_r;
    assign len_err   = len_err_r;

`ifdef FRAME_STATS_EN
    logic [15:0] good_cnt_r, bad_cnt_r;
    logic        term_s;

    assign term_s = push_s & push_entry_s[9];

    // Saturating frame statistics, counted when a terminator is generated.
    always_ff @(posedge CLK_100_RX or posedge RESET) begin
        if (RESET) begin
            good_cnt_r <= 16'h0000;
            bad_cnt_r  <= 16'h0000;
        end else begin
            if (term_s && !push_entry_s[8] && (good_cnt_r != 16'hFFFF))
                good_cnt_r <= good_cnt_r + 16'd1;
            if (((term_s && push_entry_s[8]) || len_err_s) && (bad_cnt_r != 16'hFFFF))
                bad_cnt_r <= bad_cnt_r + 16'd1;
        end
    end

    assign good_cnt = good_cnt_r;
    assign bad_cnt  = bad_cnt_r;
`endif

endmodule
